// File: rtl/ysyx_23060278_wbu_if.sv
// ysyx_23060278_wbu_if: retire, load-response, GPR-write and scoreboard-query signals of the writeback unit
interface ysyx_23060278_wbu_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32
);
  localparam int RW = $clog2(NREG);
  logic            in_valid;
  logic            in_ready;
  logic [RW-1:0]   in_rd;
  logic            in_wen;
  logic            in_is_load;
  logic [2:0]      in_funct3;
  logic [1:0]      in_addr_lo;
  logic [XLEN-1:0] in_alu_data;
  logic            mem_rvalid;
  logic            mem_rready;
  logic [XLEN-1:0] mem_rdata;
  logic            gpr_w_en;
  logic [RW-1:0]   gpr_rd;
  logic [XLEN-1:0] gpr_w_data;
  logic [RW-1:0]   q_rs1;
  logic [RW-1:0]   q_rs2;
  logic            q_rs1_busy;
  logic            q_rs2_busy;
  logic            retire;
  modport master (
    input  in_valid, in_rd, in_wen, in_is_load, in_funct3, in_addr_lo, in_alu_data,
           mem_rvalid, mem_rdata, q_rs1, q_rs2,
    output in_ready, mem_rready, gpr_w_en, gpr_rd, gpr_w_data, q_rs1_busy, q_rs2_busy, retire
  );
  modport slave (
    output in_valid, in_rd, in_wen, in_is_load, in_funct3, in_addr_lo, in_alu_data,
           mem_rvalid, mem_rdata, q_rs1, q_rs2,
    input  in_ready, mem_rready, gpr_w_en, gpr_rd, gpr_w_data, q_rs1_busy, q_rs2_busy, retire
  );
endinterface

// File: rtl/ysyx_23060278_wbu.sv
// ysyx_23060278_wbu: writeback unit driving the GPR write port with a RAW-hazard scoreboard
module ysyx_23060278_wbu #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input logic clk,
  input logic rst,
  ysyx_23060278_wbu_if.master bus
);
  localparam int RW = $clog2(NREG);
  typedef enum logic [1:0] {IDLE, WAIT_MEM, COMMIT} state_t;
  state_t          state, state_next;
  logic [RW-1:0]   rd;
  logic            wen, is_load;
  logic [2:0]      funct3;
  logic [1:0]      addr_lo;
  logic [XLEN-1:0] alu_data, load_data, ext;
  logic [NREG-1:0] sb, sb_next;
  logic [7:0]      lb;
  logic [15:0]     lh;
  logic            accept;
  assign accept = bus.in_valid & bus.in_ready;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_next;
  // next state: an accept always wins; WAIT_MEM leaves only on load data
  always_comb
    state_next = accept ? (bus.in_is_load ? WAIT_MEM : COMMIT) :
                 state == WAIT_MEM ? (bus.mem_rvalid ? COMMIT : WAIT_MEM) : IDLE;
  // outputs are decoded from state and the latched fields, so commit data is stable for the whole cycle
  always_comb begin
    bus.in_ready   = state != WAIT_MEM;
    bus.mem_rready = state == WAIT_MEM;
    bus.retire     = state == COMMIT;
    bus.gpr_w_en   = bus.retire & wen & (|rd);
    bus.gpr_rd     = rd;
    bus.gpr_w_data = is_load ? load_data : alu_data;
    bus.q_rs1_busy = sb[bus.q_rs1] & (|bus.q_rs1);
    bus.q_rs2_busy = sb[bus.q_rs2] & (|bus.q_rs2);
  end
  // byte/half extraction from the aligned word using the latched load type and offset
  always_comb begin
    lb  = bus.mem_rdata[{addr_lo, 3'b000} +: 8];
    lh  = bus.mem_rdata[{addr_lo[1], 4'b0000} +: 16];
    ext = funct3 == 3'b000 ? {{(XLEN-8){lb[7]}}, lb} :
          funct3 == 3'b001 ? {{(XLEN-16){lh[15]}}, lh} :
          funct3 == 3'b100 ? {{(XLEN-8){1'b0}}, lb} :
          funct3 == 3'b101 ? {{(XLEN-16){1'b0}}, lh} : bus.mem_rdata;
  end
  // scoreboard update: clear on commit first, then a new writer to the same index sets it again
  always_comb begin
    sb_next = sb;
    if (state == COMMIT) sb_next[rd] = 1'b0;
    if (accept && bus.in_wen && |bus.in_rd) sb_next[bus.in_rd] = 1'b1;
  end
  // latched instruction fields, load data and scoreboard bits
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd        <= '0;
      wen       <= 1'b0;
      is_load   <= 1'b0;
      funct3    <= '0;
      addr_lo   <= '0;
      alu_data  <= '0;
      load_data <= '0;
      sb        <= '0;
    end else begin
      if (accept) begin
        rd       <= bus.in_rd;
        wen      <= bus.in_wen;
        is_load  <= bus.in_is_load;
        funct3   <= bus.in_funct3;
        addr_lo  <= bus.in_addr_lo;
        alu_data <= bus.in_alu_data;
      end
      if (state == WAIT_MEM && bus.mem_rvalid) load_data <= ext;
      sb <= sb_next;
    end
endmodule

// File: tb/tb_ysyx_23060278_wbu.sv
// tb_ysyx_23060278_wbu: scoreboard-based bench for the writeback unit
module tb_ysyx_23060278_wbu;
  typedef struct packed {
    logic        w;
    logic [4:0]  rd;
    logic [31:0] d;
  } exp_t;
  logic clk, rst;
  int n_chk = 0, n_pass = 0;
  exp_t q[$];
  ysyx_23060278_wbu_if #(.XLEN(32), .NREG(32)) bus ();
  ysyx_23060278_wbu #(.XLEN(32), .NREG(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask
  task automatic issue(input logic [4:0] rd, input logic wen, input logic ld, input logic [2:0] f3,
                       input logic [1:0] alo, input logic [31:0] data, input logic push,
                       input logic [31:0] expd);
    exp_t e;
    bus.in_valid = 1; bus.in_rd = rd; bus.in_wen = wen; bus.in_is_load = ld;
    bus.in_funct3 = f3; bus.in_addr_lo = alo; bus.in_alu_data = data;
    e.w = wen && rd != 0; e.rd = rd; e.d = expd;
    if (push) q.push_back(e);
    @(posedge clk); #1;
    bus.in_valid = 0;
  endtask
  task automatic mem_resp(input logic [31:0] rdata);
    chk("mem_rready_wait", bus.mem_rready, 1);
    bus.mem_rdata = rdata; bus.mem_rvalid = 1;
    @(posedge clk); #1;
    bus.mem_rvalid = 0;
    chk("load_latency", bus.gpr_w_en, 1);
  endtask
  task automatic load(input logic [2:0] f3, input logic [1:0] alo, input logic [31:0] expd);
    issue(5'd10, 1, 1, f3, alo, 32'h0, 1, expd);
    mem_resp(32'h80FF7F01);
  endtask
  // monitor: every retire pops the oldest expected commit and compares it
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.retire) begin
      if (q.size() == 0) chk("unexpected_retire", 1, 0);
      else begin
        e = q.pop_front();
        chk("gpr_w_en", bus.gpr_w_en, e.w);
        chk("gpr_rd", bus.gpr_rd, e.rd);
        chk("gpr_w_data", bus.gpr_w_data, e.d);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    rst = 1;
    bus.in_valid = 0; bus.in_rd = 0; bus.in_wen = 0; bus.in_is_load = 0; bus.in_funct3 = 0;
    bus.in_addr_lo = 0; bus.in_alu_data = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0;
    bus.q_rs1 = 0; bus.q_rs2 = 0;
    #1;
    chk("rst_gpr_w_en", bus.gpr_w_en, 0);
    chk("rst_gpr_rd", bus.gpr_rd, 0);
    chk("rst_gpr_w_data", bus.gpr_w_data, 0);
    chk("rst_retire", bus.retire, 0);
    chk("rst_mem_rready", bus.mem_rready, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_busy", bus.q_rs1_busy, 0);
    // ALU write with scoreboard busy only during commit
    bus.q_rs1 = 5;
    issue(5'd5, 1, 0, 3'b000, 2'd0, 32'hDEADBEEF, 1, 32'hDEADBEEF);
    chk("alu_latency", bus.gpr_w_en, 1);
    chk("busy5_commit", bus.q_rs1_busy, 1);
    @(posedge clk); #1;
    chk("busy5_after", bus.q_rs1_busy, 0);
    chk("retire_one_cycle", bus.retire, 0);
    // x0 suppression
    bus.q_rs1 = 0;
    issue(5'd0, 1, 0, 3'b000, 2'd0, 32'h1234, 1, 32'h1234);
    chk("x0_retire", bus.retire, 1);
    chk("x0_busy", bus.q_rs1_busy, 0);
    @(posedge clk); #1;
    // load extension cases
    load(3'b000, 2'd1, 32'h0000007F);
    load(3'b000, 2'd2, 32'hFFFFFFFF);
    load(3'b100, 2'd3, 32'h00000080);
    load(3'b001, 2'd2, 32'hFFFF80FF);
    load(3'b101, 2'd0, 32'h00007F01);
    load(3'b010, 2'd0, 32'h80FF7F01);
    load(3'b001, 2'd3, 32'hFFFF80FF);
    @(posedge clk); #1;
    // load stall with in_valid held high
    issue(5'd3, 1, 1, 3'b010, 2'd0, 32'h0, 1, 32'hCAFEF00D);
    bus.in_valid = 1; bus.in_rd = 4; bus.in_is_load = 0; bus.in_alu_data = 32'h55;
    repeat (5) begin
      chk("stall_in_ready", bus.in_ready, 0);
      chk("stall_mem_rready", bus.mem_rready, 1);
      chk("stall_gpr_w_en", bus.gpr_w_en, 0);
      @(posedge clk); #1;
    end
    bus.in_valid = 0;
    mem_resp(32'hCAFEF00D);
    @(posedge clk); #1;
    // back-to-back same rd
    bus.q_rs2 = 7;
    issue(5'd7, 1, 0, 3'b000, 2'd0, 32'h11111111, 1, 32'h11111111);
    chk("b2b_w_en0", bus.gpr_w_en, 1);
    chk("b2b_busy0", bus.q_rs2_busy, 1);
    issue(5'd7, 1, 0, 3'b000, 2'd0, 32'h22222222, 1, 32'h22222222);
    chk("b2b_w_en1", bus.gpr_w_en, 1);
    chk("b2b_busy1", bus.q_rs2_busy, 1);
    issue(5'd7, 1, 0, 3'b000, 2'd0, 32'h33333333, 1, 32'h33333333);
    chk("b2b_w_en2", bus.gpr_w_en, 1);
    chk("b2b_busy2", bus.q_rs2_busy, 1);
    @(posedge clk); #1;
    chk("b2b_busy_clear", bus.q_rs2_busy, 0);
    chk("b2b_idle", bus.gpr_w_en, 0);
    // async reset while waiting for load data
    bus.q_rs1 = 9;
    issue(5'd9, 1, 1, 3'b010, 2'd0, 32'h0, 0, 32'h0);
    chk("pre_rst_busy9", bus.q_rs1_busy, 1);
    chk("pre_rst_mem_rready", bus.mem_rready, 1);
    #2 rst = 1;
    #1;
    chk("arst_mem_rready", bus.mem_rready, 0);
    chk("arst_gpr_w_en", bus.gpr_w_en, 0);
    chk("arst_busy9", bus.q_rs1_busy, 0);
    chk("arst_gpr_rd", bus.gpr_rd, 0);
    @(negedge clk);
    rst = 0;
    bus.mem_rdata = 32'hFFFFFFFF; bus.mem_rvalid = 1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("post_rst_gpr_w_en", bus.gpr_w_en, 0);
      chk("post_rst_retire", bus.retire, 0);
    end
    bus.mem_rvalid = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ysyx_23060278_wbu.md
Name: ysyx_23060278_wbu

Overview:
- Writeback unit: the initiator side of the GPR write port.
- Accepts retiring instructions from the EXU over a valid/ready handshake.
- For loads, waits for the memory read response, then byte/half-extends it; for all other instructions, uses the ALU result directly.
- Drives the GPR write port for exactly one cycle per instruction.
- Maintains a per-register scoreboard that the IDU queries for read-after-write hazards.

Parameters:
- XLEN, 32, data width of GPR write data, ALU result and memory read data.
- NREG, 32, number of architectural registers; scoreboard depth; register index width is log2(NREG) = 5.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  EXU has an instruction to retire.
- in_ready  output  1  WBU can accept this cycle.
- in_rd  input  5  destination register index.
- in_wen  input  1  instruction writes rd.
- in_is_load  input  1  result comes from memory.
- in_funct3  input  3  load type.
- in_addr_lo  input  2  load address bits [1:0].
- in_alu_data  input  XLEN  ALU/CSR result.
- mem_rvalid  input  1  memory read data valid.
- mem_rready  output  1  WBU waiting for load data.
- mem_rdata  input  XLEN  aligned 32-bit word read from memory.
- gpr_w_en  output  1  GPR write strobe.
- gpr_rd  output  5  GPR write index.
- gpr_w_data  output  XLEN  GPR write data.
- q_rs1  input  5  scoreboard query index 1.
- q_rs2  input  5  scoreboard query index 2.
- q_rs1_busy  output  1  rs1 has a pending write.
- q_rs2_busy  output  1  rs2 has a pending write.
- retire  output  1  one-cycle pulse per committed instruction.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; all latched fields cleared; scoreboard cleared.
  - Outputs: gpr_w_en=0, gpr_rd=0, gpr_w_data=0, retire=0, mem_rready=0, in_ready=1 once rst is released, q_*_busy=0.
- FSM states: IDLE, WAIT_MEM, COMMIT.
  - in_ready=1 in IDLE and COMMIT, 0 in WAIT_MEM.
  - An accept happens when in_valid & in_ready.
  - On accept, latch rd, wen, is_load, funct3, addr_lo, alu_data.
  - Next state is WAIT_MEM if is_load, else COMMIT.
  - COMMIT with no accept -> IDLE.
  - IDLE with no accept stays IDLE.
- WAIT_MEM:
  - mem_rready=1 for the whole state.
  - When mem_rvalid=1, latch the extended load data, then go to COMMIT.
  - mem_rvalid is ignored in any other state.
- COMMIT (registered outputs, valid for exactly this cycle):
  - gpr_w_en = latched wen & (latched rd != 0).
  - gpr_rd = latched rd.
  - gpr_w_data = load data if is_load, else alu_data.
  - retire=1.
  - In every other state, gpr_w_en=0 and retire=0.
- Latency:
  - Non-load accepted in cycle N: gpr_w_en is high in N+1.
  - Load: gpr_w_en is high in the cycle after mem_rvalid.
  - Back-to-back non-loads sustain 1 instruction/cycle.
- Load extraction: byte = mem_rdata >> (8*addr_lo); half = mem_rdata >> (16*addr_lo[1]).
  - 000 LB: sign-extend byte.
  - 001 LH: sign-extend half.
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend half.
  - 010 and any other value: full word.
  - addr_lo[0] is ignored for halves; there is no misalignment trap.
- Scoreboard (NREG bits):
  - On accept with in_wen & in_rd!=0, set bit[in_rd].
  - In COMMIT, clear bit[latched rd].
  - If both events hit the same index in the same cycle, set wins.
  - Bit 0 is never set.
  - q_rsX_busy = bit[q_rsX], combinational; index 0 always reads 0.
- Simultaneous events:
  - Accept in COMMIT overwrites the latched fields only after the current commit outputs are registered; the current commit is not lost.
- Reset during WAIT_MEM:
  - The pending load is dropped; the scoreboard is cleared.
  - A later mem_rvalid while in IDLE is ignored.

Test Plan:
- ALU write: accept rd=5, wen=1, alu_data=0xDEADBEEF -> next cycle gpr_w_en=1, gpr_rd=5, gpr_w_data=0xDEADBEEF, retire=1; q_rs1=5 busy=1 during the commit cycle, 0 after.
- x0 suppression: accept rd=0, wen=1, data=0x1234 -> gpr_w_en=0, retire=1; q_rs1=0 busy=0 throughout.
- Load extension with mem_rdata=0x80FF7F01:
  - LB addr_lo=1 -> 0x0000007F.
  - LB addr_lo=2 -> 0xFFFFFFFF.
  - LBU addr_lo=3 -> 0x00000080.
  - LH addr_lo=2 -> 0xFFFF80FF.
  - LHU addr_lo=0 -> 0x00007F01.
  - LW -> 0x80FF7F01.
  - Each written one cycle after mem_rvalid.
- Load stall: accept load, hold mem_rvalid=0 for 5 cycles -> in_ready=0, mem_rready=1, gpr_w_en=0 throughout; in_valid held high is not accepted.
- Back-to-back with same rd: accept rd=7 ×3 in consecutive cycles (non-load) -> three consecutive gpr_w_en pulses carrying the three data values; busy[7] stays 1 until the cycle after the last commit.
- Async reset in WAIT_MEM: assert rst mid-load -> outputs 0 immediately, busy bits 0; subsequent mem_rvalid=1 produces no gpr_w_en.
